// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Turns one 32-bit MEM-stage load/store into two sequential 16-bit accesses to an
// asynchronous SRAM; ~ready freezes the pipeline while the access is in flight.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  mem,
  inout  wire  [15:0]       sram_dq,
  output logic [17:0]       sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_write, is_write_nxt;
  logic             active_nxt;
  logic             dq_oe;
  logic [15:0]      dq_out;
  logic [16:0]      word_idx;
  logic [31:0]      read_q;

  // Next-state logic; the op type is latched once in IDLE so a dropped request still completes.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    is_write_nxt = is_write;
    case (state)
      IDLE: begin
        if (mem.wr_en || mem.rd_en) begin
          state_nxt    = LOW;
          cnt_nxt      = CNT_RELOAD;
          is_write_nxt = mem.wr_en;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_RELOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign active_nxt = (state_nxt == LOW) || (state_nxt == HIGH);

  // State register plus strobes registered from the next state so they change glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      dq_oe     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_write  <= is_write_nxt;
      sram_ce_n <= ~active_nxt;
      sram_we_n <= ~(active_nxt & is_write_nxt);
      sram_oe_n <= ~(active_nxt & ~is_write_nxt);
      dq_oe     <= active_nxt & is_write_nxt;
    end
  end

  // Each half is sampled on the edge that ends its last bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q <= '0;
    end else if (!is_write && cnt == '0) begin
      if (state == LOW)  read_q[15:0]  <= sram_dq;
      if (state == HIGH) read_q[31:16] <= sram_dq;
    end
  end

  // Underflow below BASE_ADDR wraps silently within the 17-bit word space.
  assign word_idx  = 17'((mem.address - 32'(BASE_ADDR)) >> 2);
  assign sram_addr = {word_idx, state == HIGH};

  // dq_oe shares its edge with we_n, so the bus is released together with the write strobe.
  assign dq_out  = (state == HIGH) ? mem.write_data[31:16] : mem.write_data[15:0];
  assign sram_dq = dq_oe ? dq_out : 16'bz;

  assign mem.read_data = read_q;
  assign mem.ready     = (state == DONE) || ((state == IDLE) && !mem.wr_en && !mem.rd_en);

endmodule
